regfile_wb_scheduler: RTL and testbench

Sequences all writes into the 32x32 register bank and tracks which registers still have a write pending.
- Arbitrates two writeback sources, ALU and load/store unit (MEM), onto the bank's single write port (we/ain/din).
- Keeps a per-register busy scoreboard, set at instruction issue and cleared when the write lands.
- Produces the decode-stage stall for RAW and WAW hazards.
- Sits between the issue/decode stage, the execution units and the register bank.

---
 rtl/regfile_wb_scheduler.sv | 163 ++++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for the 32x32 register bank: ALU/MEM onto one write port plus busy scoreboard and hazard stall.
// Define WB_RR_ARB_EN for round-robin arbitration; the default build uses fixed MEM-over-ALU priority.
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            we,
  output logic [4:0]      ain,
  output logic [XLEN-1:0] din,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic            we_r;
  logic [4:0]      ain_r;
  logic [XLEN-1:0] din_r;

  logic            alu_first_s;
  logic            grant_alu_s;
  logic            grant_mem_s;
  logic            wb_fire_s;
  logic [4:0]      wb_rd_s;
  logic [XLEN-1:0] wb_data_s;

  logic            hz_rs1_s;
  logic            hz_rs2_s;
  logic            hz_waw_s;
  logic            stall_s;
  logic            issue_set_s;

`ifdef WB_RR_ARB_EN
  logic last_mem_r;

  // Remember which source won the last completed handshake; reset value gives ALU the first turn
  always_ff @(posedge clock) begin
    if (reset) begin
      last_mem_r <= 1'b1;
    end else if (grant_mem_s) begin
      last_mem_r <= 1'b1;
    end else if (grant_alu_s) begin
      last_mem_r <= 1'b0;
    end else begin
      last_mem_r <= last_mem_r;
    end
  end

  assign alu_first_s = last_mem_r;
`else
  assign alu_first_s = 1'b0;
`endif

  // Single-grant arbitration; grants only go to a valid requester, so a grant is a completed handshake
  always_comb begin
    grant_alu_s = 1'b0;
    grant_mem_s = 1'b0;
    if (reset) begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
    end else if (alu_valid && mem_valid) begin
      grant_alu_s = alu_first_s;
      grant_mem_s = !alu_first_s;
    end else begin
      grant_alu_s = alu_valid;
      grant_mem_s = mem_valid;
    end
  end

  // Select the winning request for the write port
  always_comb begin
    wb_fire_s = grant_alu_s || grant_mem_s;
    wb_rd_s   = 5'd0;
    wb_data_s = {XLEN{1'b0}};
    if (grant_mem_s) begin
      wb_rd_s   = mem_rd;
      wb_data_s = mem_data;
    end else if (grant_alu_s) begin
      wb_rd_s   = alu_rd;
      wb_data_s = alu_data;
    end else begin
      wb_rd_s   = 5'd0;
      wb_data_s = {XLEN{1'b0}};
    end
  end

  // Register the bank write; an accepted x0 writeback completes without touching the bank
  always_ff @(posedge clock) begin
    if (reset) begin
      we_r  <= 1'b0;
      ain_r <= 5'd0;
      din_r <= {XLEN{1'b0}};
    end else if (wb_fire_s && (wb_rd_s != 5'd0)) begin
      we_r  <= 1'b1;
      ain_r <= wb_rd_s;
      din_r <= wb_data_s;
    end else begin
      we_r  <= 1'b0;
      ain_r <= ain_r;
      din_r <= din_r;
    end
  end

  // Hazard detection; a bit being cleared at this edge still reads as busy
  always_comb begin
    hz_rs1_s = (chk_rs1 != 5'd0) && busy_r[chk_rs1];
    hz_rs2_s = (chk_rs2 != 5'd0) && busy_r[chk_rs2];
    hz_waw_s = issue_valid && (issue_rd != 5'd0) && busy_r[issue_rd];
    if (reset) begin
      stall_s = 1'b1;
    end else begin
      stall_s = hz_rs1_s || hz_rs2_s || hz_waw_s;
    end
    issue_set_s = issue_valid && !stall_s && (issue_rd != 5'd0);
  end

  // Scoreboard next state: clear on bank write, then set on issue so set wins on a collision
  always_comb begin
    busy_nxt_s = busy_r;
    if (we_r) begin
      busy_nxt_s[ain_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_set_s) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
  end

  // Scoreboard state
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign stall     = stall_s;
  assign alu_ready = grant_alu_s;
  assign mem_ready = grant_mem_s;
  assign we        = we_r;
  assign ain       = ain_r;
  assign din       = din_r;
  assign busy_vec  = busy_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized bench for regfile_wb_scheduler against a cycle-level reference model of the scoreboard and arbiter.
module tb_regfile_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [4:0]  chk_rs1 = 5'd0;
  logic [4:0]  chk_rs2 = 5'd0;
  logic        stall;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic [31:0] mem_data = 32'd0;
  logic        mem_ready;
  logic        we;
  logic [4:0]  ain;
  logic [31:0] din;
  logic [31:0] busy_vec;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit [31:0] m_busy = 32'd0;
  bit        m_we = 1'b0;
  bit [4:0]  m_ain = 5'd0;
  bit [31:0] m_din = 32'd0;
  bit        m_alu_first = 1'b1;

`ifdef WB_RR_ARB_EN
  localparam logic [4:0] PAIR_FIRST  = 5'd3;
  localparam logic [4:0] PAIR_SECOND = 5'd4;
`else
  localparam logic [4:0] PAIR_FIRST  = 5'd4;
  localparam logic [4:0] PAIR_SECOND = 5'd3;
`endif

  regfile_wb_scheduler #(.XLEN(32), .NREG(32)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .we(we), .ain(ain), .din(din), .busy_vec(busy_vec)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Which source wins this cycle: 0 none, 1 ALU, 2 MEM
  function automatic int winner();
    if (reset) return 0;
    if (alu_valid && mem_valid) begin
`ifdef WB_RR_ARB_EN
      return m_alu_first ? 1 : 2;
`else
      return 2;
`endif
    end
    if (mem_valid) return 2;
    if (alu_valid) return 1;
    return 0;
  endfunction

  function automatic bit hazard();
    if (reset) return 1'b1;
    return (chk_rs1 != 0 && m_busy[chk_rs1]) || (chk_rs2 != 0 && m_busy[chk_rs2]) ||
           (issue_valid && issue_rd != 0 && m_busy[issue_rd]);
  endfunction

  // One clock cycle: check all outputs at the falling edge, advance the model at the rising edge
  task automatic step();
    int w;
    bit st;
    bit [31:0] nb;
    bit [4:0] rd;
    bit [31:0] dat;
    @(negedge clock);
    w  = winner();
    st = hazard();
    check("stall", stall, st);
    check("alu_ready", alu_ready, w == 1);
    check("mem_ready", mem_ready, w == 2);
    check("we", we, m_we);
    if (m_we) begin
      check("ain", ain, m_ain);
      check("din", din, m_din);
    end
    check("busy_vec", busy_vec, m_busy);
    @(posedge clock);
    if (reset) begin
      m_busy = 32'd0; m_we = 1'b0; m_ain = 5'd0; m_din = 32'd0; m_alu_first = 1'b1;
    end else begin
      nb = m_busy;
      if (m_we) nb[m_ain] = 1'b0;
      if (issue_valid && !st && issue_rd != 0) nb[issue_rd] = 1'b1;
      m_busy = nb;
      m_we = 1'b0;
      if (w != 0) begin
        rd  = (w == 1) ? alu_rd : mem_rd;
        dat = (w == 1) ? alu_data : mem_data;
        m_alu_first = (w == 2);
        if (rd != 0) begin
          m_we = 1'b1; m_ain = rd; m_din = dat;
        end
      end
    end
    #1;
    if (w == 1) alu_valid = 1'b0;
    if (w == 2) mem_valid = 1'b0;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_we", we, 1'b0);
    check("rst_ain", ain, 5'd0);
    check("rst_din", din, 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h5;
    step();
    alu_valid = 1'b0;
    reset = 1'b0;

    // Issue to x5, then write it back from the ALU
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    clear_inputs();
    check("tp1_busy", busy_vec, 32'h0000_0020);
    chk_rs1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    check("tp1_we", we, 1'b1);
    check("tp1_ain", ain, 5'd5);
    check("tp1_din", din, 32'hDEAD_BEEF);
    step();
    check("tp1_clr", busy_vec[5], 1'b0);
    step();
    clear_inputs();

    // Simultaneous ALU/MEM pairs right after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
    step();
    check("tp2_first", ain, PAIR_FIRST);
    step();
    check("tp2_second", ain, PAIR_SECOND);
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h44;
    step();
    step();

    // x0 writeback, x0 issue, x0 source
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0; chk_rs1 = 5'd0;
    step();
    check("tp3_we", we, 1'b0);
    check("tp3_busy", busy_vec, 32'd0);
    clear_inputs();

    // WAW on x7: the second issue waits until the write has landed
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    step();
    check("tp4_we", we, 1'b1);
    check("tp4_held", busy_vec[7], 1'b1);
    step();
    check("tp4_cleared", busy_vec[7], 1'b0);
    step();
    check("tp4_reissued", busy_vec[7], 1'b1);
    clear_inputs();

    // Reset in the middle of activity with a pending ALU request
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int r = 4; r < 8; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      step();
    end
    clear_inputs();
    check("tp5_busy", busy_vec, 32'h0000_00F0);
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    step();
    check("tp5_rst_busy", busy_vec, 32'd0);
    check("tp5_rst_we", we, 1'b0);
    reset = 1'b0;
    step();
    check("tp5_after_we", we, 1'b1);
    check("tp5_after_ain", ain, 5'd9);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      chk_rs1 = 5'($urandom_range(0, 7));
      chk_rs2 = 5'($urandom_range(0, 7));
      if (!alu_valid && $urandom_range(0, 1) == 1) begin
        alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!mem_valid && $urandom_range(0, 2) == 0) begin
        mem_valid = 1'b1; mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
